inst_fetch_ctrl: RTL

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues word addresses to a one-cycle-latency
// instruction RAM and buffers returned words in a small FIFO toward the consumer.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          AW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [31:0]   ram_d,
    input  logic [31:0]   ram_spo,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst
);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_issue_pc;
    logic [31:0]     r_inflight_pc;
    logic            r_inflight;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]     r_fifo_inst [FIFO_DEPTH];
    logic            w_deq;
    logic            w_enq;
    logic            w_issue;
    logic [CW:0]     w_occupancy;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: any redirect forces a one-cycle FLUSH
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = redirect_valid ? ST_FLUSH : ST_FETCH;
            ST_FETCH: w_state_nxt = redirect_valid ? ST_FLUSH : ST_FETCH;
            ST_FLUSH: w_state_nxt = redirect_valid ? ST_FLUSH : ST_FETCH;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake, issue throttle and RAM port
    always_comb begin
        out_valid   = (r_count != '0) & ~redirect_valid & (r_state != ST_FLUSH);
        w_deq       = out_valid & out_ready;
        w_enq       = r_inflight & ~redirect_valid;
        // Reserve a slot for the word already in flight so the FIFO cannot overflow
        w_occupancy = {1'b0, r_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_deq);
        w_issue     = (r_state == ST_FETCH) & ~redirect_valid & (w_occupancy < DEPTH_W);
        ram_we      = 1'b0;
        ram_d       = 32'h0000_0000;
        ram_a       = r_issue_pc[AW+1:2];
        out_pc      = r_fifo_pc[r_rd_ptr];
        out_inst    = r_fifo_inst[r_rd_ptr];
    end

    // Fetch address and in-flight tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_pc    <= RESET_PC;
            r_inflight_pc <= RESET_PC;
            r_inflight    <= 1'b0;
        end else if (redirect_valid) begin
            r_issue_pc <= redirect_pc & 32'hffff_fffc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_issue_pc;
            r_issue_pc    <= r_issue_pc + 32'd4;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // FIFO storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_pc[i]   <= 32'h0000_0000;
                r_fifo_inst[i] <= 32'h0000_0000;
            end
        end else if (w_enq) begin
            r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
            r_fifo_inst[r_wr_ptr] <= ram_spo;
        end
    end

endmodule
